grf_wb_arb: RTL and testbench

Writeback arbiter that drives the single write port of the 16×32 general register file. It accepts results from the ALU channel and the load channel over valid/ready handshakes and buffers load results in a 2-entry FIFO. It aligns and extends load data and presents one registered write per cycle: address, byte enables, data and active-low chip select. It also exports a pending-write mask for issue-stage hazard checks.

---
 rtl/grf_wb_arb_pkg.sv | 32 +++
 rtl/grf_wb_arb_if.sv | 43 ++++
 rtl/grf_wb_arb_ld_align.sv | 52 +++++
 rtl/grf_wb_arb.sv | 125 ++++++++++++
 tb/tb_grf_wb_arb.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grf_wb_arb_pkg.sv
// rtl/grf_wb_arb_pkg.sv - shared widths, load size encodings and writeback entry type
package grf_pkg;

  localparam int REG_AW   = 4;
  localparam int DATA_W   = 32;
  localparam int WEN_W    = DATA_W / 8;
  localparam int NUM_REGS = 1 << REG_AW;

  // Load access size; both upper encodings mean a full word.
  typedef enum logic [1:0] {
    SZ_BYTE     = 2'd0,
    SZ_HALF     = 2'd1,
    SZ_WORD     = 2'd2,
    SZ_WORD_ALT = 2'd3
  } ld_size_e;

  // One pending register file write.
  typedef struct packed {
    logic [REG_AW-1:0] waddr;
    logic [WEN_W-1:0]  wen;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Register address to its bit in the pending-write mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
    logic [NUM_REGS-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/grf_wb_arb_if.sv
// rtl/grf_wb_arb_if.sv - ALU/load result channels and register file write port
interface grf_wb_arb_if;
  import grf_pkg::*;

  logic                i_alu_valid;
  logic [REG_AW-1:0]   i_alu_waddr;
  logic [DATA_W-1:0]   i_alu_data;
  logic                o_alu_ready;

  logic                i_ld_valid;
  logic [REG_AW-1:0]   i_ld_waddr;
  logic [DATA_W-1:0]   i_ld_data;
  logic [1:0]          i_ld_size;
  logic [1:0]          i_ld_offset;
  logic                i_ld_sext;
  logic                i_ld_ins;
  logic                o_ld_ready;

  logic [REG_AW-1:0]   o_waddr;
  logic [WEN_W-1:0]    o_wen;
  logic [DATA_W-1:0]   o_din;
  logic                o_cs_b;
  logic [NUM_REGS-1:0] o_busy;

  // Producer side: execution units and the issue stage.
  modport master (
    output i_alu_valid, i_alu_waddr, i_alu_data,
    input  o_alu_ready,
    output i_ld_valid, i_ld_waddr, i_ld_data, i_ld_size, i_ld_offset, i_ld_sext, i_ld_ins,
    input  o_ld_ready,
    input  o_waddr, o_wen, o_din, o_cs_b, o_busy
  );

  // Arbiter side.
  modport slave (
    input  i_alu_valid, i_alu_waddr, i_alu_data,
    output o_alu_ready,
    input  i_ld_valid, i_ld_waddr, i_ld_data, i_ld_size, i_ld_offset, i_ld_sext, i_ld_ins,
    output o_ld_ready,
    output o_waddr, o_wen, o_din, o_cs_b, o_busy
  );

endinterface

// File: rtl/grf_wb_arb_ld_align.sv
// rtl/grf_wb_arb_ld_align.sv - combinational load data aligner and extender
module ld_align
  import grf_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              sext,
  input  logic              ins,
  input  logic [DATA_W-1:0] din,
  output logic [WEN_W-1:0]  wen,
  output logic [DATA_W-1:0] dout
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and halfword lanes; halfword ignores offset[0].
  always_comb begin
    sel_half = offset[1] ? din[31:16] : din[15:0];
    case (offset)
      2'd0:    sel_byte = din[7:0];
      2'd1:    sel_byte = din[15:8];
      2'd2:    sel_byte = din[23:16];
      default: sel_byte = din[31:24];
    endcase
  end

  // Extend mode moves the lane down and fills; insert mode keeps data and narrows wen.
  always_comb begin
    wen  = '1;
    dout = din;
    case (ld_size_e'(size))
      SZ_BYTE: begin
        if (ins) begin
          wen = 4'b0001 << offset;
        end else begin
          dout = {{24{sext & sel_byte[7]}}, sel_byte};
        end
      end
      SZ_HALF: begin
        if (ins) begin
          wen = offset[1] ? 4'b1100 : 4'b0011;
        end else begin
          dout = {{16{sext & sel_half[15]}}, sel_half};
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/grf_wb_arb.sv
// rtl/grf_wb_arb.sv - register file writeback arbiter with 2-entry load FIFO
module grf_wb_arb
  import grf_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstb,
  input  logic        i_clk_en,
  grf_wb_arb_if.slave bus
);

  wb_entry_t           fifo_mem [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;

  logic [WEN_W-1:0]    ld_wen;
  logic [DATA_W-1:0]   ld_dout;
  wb_entry_t           ld_entry;
  wb_entry_t           head;
  wb_entry_t           out_q;
  logic                cs_b_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic                ld_push;
  logic                fifo_pop;
  logic                alu_take;
  logic [NUM_REGS-1:0] busy;

  ld_align u_ld_align (
    .size   (bus.i_ld_size),
    .offset (bus.i_ld_offset),
    .sext   (bus.i_ld_sext),
    .ins    (bus.i_ld_ins),
    .din    (bus.i_ld_data),
    .wen    (ld_wen),
    .dout   (ld_dout)
  );

  assign ld_entry   = {bus.i_ld_waddr, ld_wen, ld_dout};
  assign head       = fifo_mem[rd_ptr];
  assign fifo_full  = (count == 2'd2);
  assign fifo_empty = (count == 2'd0);

  // Readies depend on FIFO occupancy only, never on the other channel's valid.
  assign bus.o_alu_ready = i_clk_en & ~fifo_full;
  assign bus.o_ld_ready  = i_clk_en & (count < 2'd2);
  assign ld_push         = bus.i_ld_valid & bus.o_ld_ready;

  // Pick one writer per enabled cycle: FIFO head when full or when ALU is idle.
  always_comb begin
    fifo_pop = 1'b0;
    alu_take = 1'b0;
    if (i_clk_en) begin
      if (!fifo_empty && (fifo_full || !bus.i_alu_valid)) begin
        fifo_pop = 1'b1;
      end else if (bus.i_alu_valid) begin
        alu_take = 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care until count says an entry is valid.
  always_ff @(posedge i_clk) begin
    if (ld_push) begin
      fifo_mem[wr_ptr] <= ld_entry;
    end
  end

  // FIFO pointers and occupancy; push and pop together at count=1 leaves count unchanged.
  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (ld_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (fifo_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, ld_push} - {1'b0, fifo_pop};
    end
  end

  // Registered write port; address/enables/data hold while idle, strobe deasserts.
  always_ff @(posedge i_clk) begin
    if (!i_rstb) begin
      out_q  <= '0;
      cs_b_q <= 1'b1;
    end else if (i_clk_en) begin
      if (fifo_pop) begin
        out_q  <= head;
        cs_b_q <= 1'b0;
      end else if (alu_take) begin
        out_q  <= {bus.i_alu_waddr, {WEN_W{1'b1}}, bus.i_alu_data};
        cs_b_q <= 1'b0;
      end else begin
        cs_b_q <= 1'b1;
      end
    end
  end

  // Pending-write mask: every valid FIFO entry plus a live output stage.
  always_comb begin
    busy = '0;
    if (count != 2'd0) begin
      busy = busy | reg_onehot(fifo_mem[rd_ptr].waddr);
    end
    if (count == 2'd2) begin
      busy = busy | reg_onehot(fifo_mem[~rd_ptr].waddr);
    end
    if (!cs_b_q) begin
      busy = busy | reg_onehot(out_q.waddr);
    end
  end

  assign bus.o_waddr = out_q.waddr;
  assign bus.o_wen   = out_q.wen;
  assign bus.o_din   = out_q.data;
  assign bus.o_cs_b  = cs_b_q;
  assign bus.o_busy  = busy;

endmodule

// File: tb/tb_grf_wb_arb.sv
// tb/tb_grf_wb_arb.sv - self-checking bench for the writeback arbiter
module tb_grf_wb_arb;
  import grf_pkg::*;

  logic clk = 1'b0;
  logic rstb;
  logic clk_en;
  int   checks = 0;
  int   errors = 0;

  grf_wb_arb_if bus();

  grf_wb_arb dut (
    .i_clk    (clk),
    .i_rstb   (rstb),
    .i_clk_en (clk_en),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Expected writes: ALU results and formatted load results, in acceptance order.
  wb_entry_t   alu_q[$];
  wb_entry_t   ld_q[$];
  bit          disp_alu = 1'b0;
  logic [15:0] exp_busy;
  wb_entry_t   got;

  function automatic wb_entry_t fmt(input logic [3:0] a, input logic [1:0] sz,
                                    input logic [1:0] off, input logic sx,
                                    input logic ins, input logic [31:0] d);
    wb_entry_t  e;
    logic [7:0] b [4];
    int         lo;
    for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
    e.waddr = a;
    e.wen   = 4'hF;
    e.data  = d;
    if (sz == 2'd1) begin
      lo = off[1] ? 2 : 0;
      if (ins) e.wen = (lo == 2) ? 4'b1100 : 4'b0011;
      else     e.data = {{16{sx & b[lo+1][7]}}, b[lo+1], b[lo]};
    end else if (sz == 2'd0) begin
      if (ins) begin
        e.wen      = 4'b0000;
        e.wen[off] = 1'b1;
      end else begin
        e.data = {{24{sx & b[off][7]}}, b[off]};
      end
    end
    return e;
  endfunction

  // Scoreboard monitor: predicts busy, checks each captured write, records acceptances.
  always @(negedge clk) begin
    if (!rstb) begin
      alu_q.delete();
      ld_q.delete();
      disp_alu = 1'b0;
    end else begin
      exp_busy = '0;
      foreach (ld_q[i]) exp_busy[ld_q[i].waddr] = 1'b1;
      if (disp_alu && alu_q.size() > 0) exp_busy[alu_q[0].waddr] = 1'b1;
      checks++;
      if (bus.o_busy !== exp_busy) begin
        errors++;
        $display("FAIL busy_track actual %h expected %h at %0t", bus.o_busy, exp_busy, $time);
      end
      if (clk_en) begin
        got = {bus.o_waddr, bus.o_wen, bus.o_din};
        if (disp_alu) begin
          checks++;
          if (alu_q.size() == 0 || bus.o_cs_b !== 1'b0 || got !== alu_q[0]) begin
            errors++;
            $display("FAIL alu_write actual cs_b=%b %h expected cs_b=0 %h", bus.o_cs_b, got,
                     (alu_q.size() > 0) ? alu_q[0] : '0);
          end
          if (alu_q.size() > 0) void'(alu_q.pop_front());
        end else if (bus.o_cs_b === 1'b0) begin
          checks++;
          if (ld_q.size() == 0) begin
            errors++;
            $display("FAIL load_write actual %h expected no write", got);
          end else begin
            if (got !== ld_q[0]) begin
              errors++;
              $display("FAIL load_write actual %h expected %h", got, ld_q[0]);
            end
            void'(ld_q.pop_front());
          end
        end
        disp_alu = bus.i_alu_valid && bus.o_alu_ready;
        if (bus.i_alu_valid && bus.o_alu_ready)
          alu_q.push_back({bus.i_alu_waddr, 4'hF, bus.i_alu_data});
        if (bus.i_ld_valid && bus.o_ld_ready)
          ld_q.push_back(fmt(bus.i_ld_waddr, bus.i_ld_size, bus.i_ld_offset,
                             bus.i_ld_sext, bus.i_ld_ins, bus.i_ld_data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_alu_valid = 1'b0;
    bus.i_alu_waddr = '0;
    bus.i_alu_data  = '0;
    bus.i_ld_valid  = 1'b0;
    bus.i_ld_waddr  = '0;
    bus.i_ld_data   = '0;
    bus.i_ld_size   = 2'd2;
    bus.i_ld_offset = '0;
    bus.i_ld_sext   = 1'b0;
    bus.i_ld_ins    = 1'b0;
  endtask

  task automatic drive_ld(input logic [3:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input logic [1:0] off, input logic sx, input logic ins);
    bus.i_ld_valid  = 1'b1;
    bus.i_ld_waddr  = a;
    bus.i_ld_data   = d;
    bus.i_ld_size   = sz;
    bus.i_ld_offset = off;
    bus.i_ld_sext   = sx;
    bus.i_ld_ins    = ins;
  endtask

  task automatic drain(input string name);
    int n = 0;
    idle_inputs();
    while ((alu_q.size() != 0 || ld_q.size() != 0 || bus.o_cs_b !== 1'b1) && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (alu_q.size() != 0 || ld_q.size() != 0 || bus.o_cs_b !== 1'b1) begin
      errors++;
      $display("FAIL %s_drain actual alu=%0d ld=%0d cs_b=%b expected all empty", name,
               alu_q.size(), ld_q.size(), bus.o_cs_b);
    end
  endtask

  task automatic test_reset();
    rstb   = 1'b0;
    clk_en = 1'b1;
    idle_inputs();
    step();
    step();
    rstb = 1'b1;
    checks++;
    if (bus.o_cs_b !== 1'b1 || bus.o_wen !== 4'h0 || bus.o_busy !== 16'h0 ||
        bus.o_waddr !== 4'h0 || bus.o_din !== 32'h0 ||
        bus.o_alu_ready !== 1'b1 || bus.o_ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset actual cs_b=%b wen=%h busy=%h waddr=%h din=%h rdy=%b%b expected 1 0 0 0 0 11",
               bus.o_cs_b, bus.o_wen, bus.o_busy, bus.o_waddr, bus.o_din,
               bus.o_alu_ready, bus.o_ld_ready);
    end
  endtask

  task automatic test_alu_write();
    bus.i_alu_valid = 1'b1;
    bus.i_alu_waddr = 4'd5;
    bus.i_alu_data  = 32'hDEADBEEF;
    step();
    bus.i_alu_valid = 1'b0;
    checks++;
    if (bus.o_waddr !== 4'd5 || bus.o_wen !== 4'hF || bus.o_din !== 32'hDEADBEEF ||
        bus.o_cs_b !== 1'b0 || bus.o_busy !== 16'h0020) begin
      errors++;
      $display("FAIL alu_r5 actual %h %h %h cs_b=%b busy=%h expected 5 f deadbeef 0 0020",
               bus.o_waddr, bus.o_wen, bus.o_din, bus.o_cs_b, bus.o_busy);
    end
    step();
    checks++;
    if (bus.o_cs_b !== 1'b1 || bus.o_busy !== 16'h0) begin
      errors++;
      $display("FAIL alu_r5_idle actual cs_b=%b busy=%h expected 1 0000", bus.o_cs_b, bus.o_busy);
    end
  endtask

  task automatic ld_case(input string name, input logic [1:0] sz, input logic [1:0] off,
                         input logic sx, input logic ins,
                         input logic [3:0] exp_wen, input logic [31:0] exp_din);
    drive_ld(4'd3, 32'h80FF7F01, sz, off, sx, ins);
    step();
    bus.i_ld_valid = 1'b0;
    checks++;
    if (bus.o_cs_b !== 1'b1 || bus.o_busy !== 16'h0008) begin
      errors++;
      $display("FAIL %s_queued actual cs_b=%b busy=%h expected 1 0008", name, bus.o_cs_b, bus.o_busy);
    end
    step();
    checks++;
    if (bus.o_cs_b !== 1'b0 || bus.o_waddr !== 4'd3 || bus.o_wen !== exp_wen ||
        bus.o_din !== exp_din) begin
      errors++;
      $display("FAIL %s actual cs_b=%b waddr=%h wen=%b din=%h expected 0 3 %b %h", name,
               bus.o_cs_b, bus.o_waddr, bus.o_wen, bus.o_din, exp_wen, exp_din);
    end
    step();
  endtask

  task automatic test_ld_format();
    ld_case("ld_byte_sext", 2'd0, 2'd3, 1'b1, 1'b0, 4'b1111, 32'hFFFFFF80);
    ld_case("ld_half_zext", 2'd1, 2'd2, 1'b0, 1'b0, 4'b1111, 32'h000080FF);
    ld_case("ld_byte_ins",  2'd0, 2'd1, 1'b0, 1'b1, 4'b0010, 32'h80FF7F01);
    ld_case("ld_half_ins",  2'd1, 2'd3, 1'b1, 1'b1, 4'b1100, 32'h80FF7F01);
    ld_case("ld_half_sext", 2'd1, 2'd0, 1'b1, 1'b0, 4'b1111, 32'h00007F01);
  endtask

  task automatic test_contention();
    int alu_sent = 0;
    int ld_sent  = 0;
    bit saw_alu_lo = 1'b0;
    bit saw_ld_lo  = 1'b0;
    bit alu_acc;
    bit ld_acc;
    for (int cyc = 0; cyc < 40 && (alu_sent < 8 || ld_sent < 3); cyc++) begin
      bus.i_alu_valid = (alu_sent < 8);
      bus.i_alu_waddr = 4'(8 + alu_sent);
      bus.i_alu_data  = 32'hA000_0000 + 32'(alu_sent);
      if (ld_sent < 3) drive_ld(4'(1 + ld_sent), 32'h1111_1111 * 32'(ld_sent + 1), 2'd2, 2'd0, 1'b0, 1'b0);
      else bus.i_ld_valid = 1'b0;
      checks++;
      if (bus.o_ld_ready !== bus.o_alu_ready) begin
        errors++;
        $display("FAIL contention_ready actual alu=%b ld=%b expected equal", bus.o_alu_ready, bus.o_ld_ready);
      end
      alu_acc = bus.i_alu_valid && bus.o_alu_ready;
      ld_acc  = bus.i_ld_valid && bus.o_ld_ready;
      if (bus.i_alu_valid && !bus.o_alu_ready) saw_alu_lo = 1'b1;
      if (bus.i_ld_valid && !bus.o_ld_ready) saw_ld_lo = 1'b1;
      step();
      if (alu_acc) alu_sent++;
      if (ld_acc) ld_sent++;
    end
    checks++;
    if (!saw_alu_lo || !saw_ld_lo || alu_sent != 8 || ld_sent != 3) begin
      errors++;
      $display("FAIL contention actual alu_lo=%b ld_lo=%b alu=%0d ld=%0d expected 1 1 8 3",
               saw_alu_lo, saw_ld_lo, alu_sent, ld_sent);
    end
    drain("contention");
  endtask

  task automatic test_clk_en_stall();
    bus.i_alu_valid = 1'b1;
    bus.i_alu_waddr = 4'd7;
    bus.i_alu_data  = 32'h7777_0007;
    drive_ld(4'd9, 32'h9999_0009, 2'd2, 2'd0, 1'b0, 1'b0);
    step();
    clk_en          = 1'b0;
    bus.i_alu_waddr = 4'd6;
    bus.i_alu_data  = 32'h6666_0006;
    drive_ld(4'd10, 32'hAAAA_000A, 2'd0, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.o_waddr !== 4'd7 || bus.o_din !== 32'h7777_0007 || bus.o_cs_b !== 1'b0 ||
          bus.o_alu_ready !== 1'b0 || bus.o_ld_ready !== 1'b0 || bus.o_busy !== 16'h0280) begin
        errors++;
        $display("FAIL stall_%0d actual waddr=%h din=%h cs_b=%b rdy=%b%b busy=%h expected 7 77770007 0 00 0280",
                 i, bus.o_waddr, bus.o_din, bus.o_cs_b, bus.o_alu_ready, bus.o_ld_ready, bus.o_busy);
      end
    end
    clk_en = 1'b1;
    step();
    drain("stall");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      clk_en          = ($urandom_range(0, 9) != 0);
      bus.i_alu_valid = $urandom_range(0, 1) != 0;
      bus.i_alu_waddr = 4'($urandom);
      bus.i_alu_data  = $urandom;
      bus.i_ld_valid  = $urandom_range(0, 2) != 0;
      bus.i_ld_waddr  = 4'($urandom);
      bus.i_ld_data   = $urandom;
      bus.i_ld_size   = 2'($urandom);
      bus.i_ld_offset = 2'($urandom);
      bus.i_ld_sext   = 1'($urandom);
      bus.i_ld_ins    = 1'($urandom);
      step();
    end
    clk_en = 1'b1;
    drain("random");
  endtask

  task automatic test_reset_mid();
    bus.i_alu_valid = 1'b1;
    bus.i_alu_waddr = 4'd12;
    bus.i_alu_data  = 32'hC000_000C;
    drive_ld(4'd1, 32'h0101_0101, 2'd2, 2'd0, 1'b0, 1'b0);
    step();
    bus.i_alu_waddr = 4'd13;
    bus.i_alu_data  = 32'hD000_000D;
    drive_ld(4'd2, 32'h0202_0202, 2'd2, 2'd0, 1'b0, 1'b0);
    step();
    checks++;
    if (bus.o_cs_b !== 1'b0 || bus.o_busy !== 16'h2006 || bus.o_ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pre actual cs_b=%b busy=%h ld_rdy=%b expected 0 2006 0",
               bus.o_cs_b, bus.o_busy, bus.o_ld_ready);
    end
    rstb = 1'b0;
    idle_inputs();
    step();
    rstb = 1'b1;
    checks++;
    if (bus.o_cs_b !== 1'b1 || bus.o_busy !== 16'h0 || bus.o_wen !== 4'h0 ||
        bus.o_waddr !== 4'h0 || bus.o_din !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid actual cs_b=%b busy=%h wen=%h waddr=%h din=%h expected 1 0 0 0 0",
               bus.o_cs_b, bus.o_busy, bus.o_wen, bus.o_waddr, bus.o_din);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.o_cs_b !== 1'b1 || bus.o_busy !== 16'h0) begin
        errors++;
        $display("FAIL rst_mid_after_%0d actual cs_b=%b busy=%h expected 1 0000", i, bus.o_cs_b, bus.o_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_ld_format();
    test_contention();
    test_clk_en_stall();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
